pc_target_unit: RTL

- Parametrised successor to the fixed 13-to-14-bit IR left-shift used for PC targets.
- Owns the program counter register and computes the next PC every enabled cycle: sequential, conditional PC-relative branch, absolute jump, call and return.
- Call/return use a small return-address stack (RAS).
- Sits between the control unit (op/cond/en) and instruction memory (PC output).

---
 rtl/pc_unit_pkg.sv | 17 +
 rtl/ret_addr_stack.sv | 57 +++++
 rtl/pc_target_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared op encodings and step helper for the PC target unit.
package pc_unit_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_NEXT   = 3'd0;
    localparam logic [OP_W-1:0] OP_BRANCH = 3'd1;
    localparam logic [OP_W-1:0] OP_JUMP   = 3'd2;
    localparam logic [OP_W-1:0] OP_CALL   = 3'd3;
    localparam logic [OP_W-1:0] OP_RET    = 3'd4;

    // Sequential PC increment for a given immediate shift.
    function automatic int unsigned stepSize(input int unsigned shift);
        return 32'd1 << shift;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack; a push while full silently drops the oldest entry.
module ret_addr_stack #(
    parameter int unsigned PC_W      = 16,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] pushData,
    output logic [PC_W-1:0] top,
    output logic            full,
    output logic            empty,
    output logic            overflow
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_W-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] topIdx;
    logic [PTR_W-1:0] nextIdx;
    logic [CNT_W-1:0] count;

    // wrPtr is the next free slot; when full it lands on the oldest entry.
    assign topIdx  = (wrPtr == '0) ? PTR_W'(RAS_DEPTH - 1) : wrPtr - PTR_W'(1);
    assign nextIdx = (wrPtr == PTR_W'(RAS_DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);

    assign top      = mem[topIdx];
    assign full     = (count == CNT_W'(RAS_DEPTH));
    assign empty    = (count == '0);
    assign overflow = push && full;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            wrPtr <= '0;
            count <= '0;
        end else if (push) begin
            wrPtr <= nextIdx;
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            wrPtr <= topIdx;
            count <= count - CNT_W'(1);
        end
    end

    // Storage is deliberately not reset; a zero count makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

endmodule

// File: rtl/pc_target_unit.sv
// Program counter register with next-PC selection for step, branch, jump, call and return.
module pc_target_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     IMM_W     = 13,
    parameter int unsigned     SHIFT     = 1,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic             cond,
    input  logic [IMM_W-1:0] imm,
    output logic [PC_W-1:0]  PC,
    output logic             redirect,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam logic [PC_W-1:0] STEP = PC_W'(stepSize(SHIFT));
    // Bits replaced by an absolute target; everything above is kept from the current PC.
    localparam logic [PC_W-1:0] ABS_MASK = (IMM_W + SHIFT >= PC_W) ? {PC_W{1'b1}}
                                         : ((PC_W'(1) << (IMM_W + SHIFT)) - PC_W'(1));

    logic [PC_W-1:0] pcPlusStep;
    logic [PC_W-1:0] sextImm;
    logic [PC_W-1:0] absRaw;
    logic [PC_W-1:0] absTarget;
    logic [PC_W-1:0] rasTop;
    logic            rasOverflow;

    logic [PC_W-1:0] nextPc;
    logic            nextRedirect;
    logic            doPush;
    logic            doPop;
    logic            setUnf;

    assign pcPlusStep = PC + STEP;
    assign sextImm    = PC_W'($signed(imm)) << SHIFT;
    assign absRaw     = PC_W'(imm) << SHIFT;
    assign absTarget  = (PC & ~ABS_MASK) | (absRaw & ABS_MASK);

    ret_addr_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk      (CLK),
        .rstN     (Reset_n),
        .push     (doPush && en && Reset_n),
        .pop      (doPop && en && Reset_n),
        .pushData (pcPlusStep),
        .top      (rasTop),
        .full     (ras_full),
        .empty    (ras_empty),
        .overflow (rasOverflow)
    );

    // Next-PC selection; reserved op codes fall through to a sequential step.
    always_comb begin
        nextPc       = pcPlusStep;
        nextRedirect = 1'b0;
        doPush       = 1'b0;
        doPop        = 1'b0;
        setUnf       = 1'b0;
        case (op)
            OP_BRANCH: begin
                if (cond) begin
                    nextPc       = PC + sextImm;
                    nextRedirect = 1'b1;
                end
            end
            OP_JUMP: begin
                nextPc       = absTarget;
                nextRedirect = 1'b1;
            end
            OP_CALL: begin
                nextPc       = absTarget;
                nextRedirect = 1'b1;
                doPush       = 1'b1;
            end
            OP_RET: begin
                if (!ras_empty) begin
                    nextPc       = rasTop;
                    nextRedirect = 1'b1;
                    doPop        = 1'b1;
                end else begin
                    setUnf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            PC       <= RESET_PC;
            redirect <= 1'b0;
            ras_ovf  <= 1'b0;
            ras_unf  <= 1'b0;
        end else if (en) begin
            PC       <= nextPc;
            redirect <= nextRedirect;
            ras_ovf  <= ras_ovf | rasOverflow;
            ras_unf  <= ras_unf | setUnf;
        end else begin
            redirect <= 1'b0;
        end
    end

endmodule
